cmd_issuer: RTL and testbench
=============================

// Module: cmd_issuer
// PURPOSE
//  Host-side initiator for the 16-bit command/response link. Accepts one command word,
//  serialises it as two bytes (high first) into the byte-level UART transmitter, then waits
//  for the single response byte from the UART receiver. Sits between the test host / remote
//  controller and the UART pair that talks to the maze runner's command processor.
// PARAMETERS
//  TIMEOUT_CYC  1_000_000  cycles to wait in RESP before giving up (only with RESP_TIMEOUT_EN)
// PORTS
//  clk         in   1   system clock, all flops on posedge
//  rst         in   1   asynchronous, active-high reset
//  cmd         in   16  command word; sampled only on the cycle snd_cmd is accepted
//  snd_cmd     in   1   one-cycle request to send cmd
//  tx_data     out  8   byte to UART transmitter
//  trmt        out  1   one-cycle pulse: start UART transmission of tx_data
//  tx_done     in   1   UART transmitter finished current byte (one-cycle pulse)
//  rx_rdy      in   1   UART receiver holds a byte (level, until cleared)
//  rx_data     in   8   received byte
//  clr_rx_rdy  out  1   one-cycle pulse: consume receiver byte
//  cmd_snt     out  1   both command bytes transmitted (sticky)
//  resp        out  8   last response byte
//  resp_rdy    out  1   resp valid (sticky)
//  busy        out  1   high in any state other than IDLE
//  timeout     out  1   response timeout (sticky); tied 0 without RESP_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state=IDLE; tx_data=0, trmt=0, clr_rx_rdy=0, cmd_snt=0, resp=0, resp_rdy=0,
//   busy=0, timeout=0; internal cmd_reg=0. Reset mid-operation aborts silently, no trmt issued.
//  trmt, tx_data, cmd_snt, resp, resp_rdy, timeout are registered; clr_rx_rdy, busy comb.
//  FSM states: IDLE, HIGH, LOW, RESP.
//   IDLE: snd_cmd -> cmd_reg<=cmd; clear cmd_snt/resp_rdy/timeout; next cycle trmt=1 with
//    tx_data=cmd[15:8]; go HIGH. Latency snd_cmd(N) -> trmt(N+1).
//   HIGH: on tx_done -> trmt=1 next cycle, tx_data=cmd_reg[7:0]; go LOW.
//   LOW:  on tx_done -> cmd_snt<=1; go RESP.
//   RESP: on rx_rdy -> resp<=rx_data, resp_rdy<=1, clr_rx_rdy=1 same cycle; go IDLE.
//  tx_data holds its value between loads. trmt never high two consecutive cycles.
//  snd_cmd while busy: ignored, no effect on cmd_reg or flags.
//  snd_cmd in IDLE coincident with stray rx_rdy: command accepted and byte discarded.
//  rx_rdy in IDLE/HIGH/LOW: stray byte; clr_rx_rdy pulsed, resp/resp_rdy unchanged.
//  tx_done in IDLE or RESP: ignored.
//  Any response value accepted (positive ack 0xA5 or other); no checking here.
// CONFIGURATION
//  RESP_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYC) bits) cleared on RESP entry,
//   increments each RESP cycle without rx_rdy; at count TIMEOUT_CYC-1 -> timeout<=1,
//   resp_rdy stays 0, go IDLE. rx_rdy on the terminal cycle wins (response, no timeout).
//  RESP_TIMEOUT_EN undefined: no counter; RESP waits indefinitely; timeout constant 0.
// TESTING
//  1 cmd=16'h2BFF, snd_cmd; tx_done 20 cyc after each trmt -> trmt w/ tx_data=8'h2B then
//    8'hFF, cmd_snt=1 after 2nd tx_done, busy until response.
//  2 After (1), rx_rdy=1 rx_data=8'hA5 -> clr_rx_rdy 1 cycle, resp=8'hA5, resp_rdy=1, IDLE.
//  3 snd_cmd cmd=16'h4002 while in LOW -> ignored; second byte still 8'hFF from cmd_reg.
//  4 rx_rdy with 8'h33 while in HIGH -> clr_rx_rdy pulse, resp_rdy stays 0, resp unchanged.
//  5 Assert rst during LOW -> all outputs 0 immediately; no further trmt after release.
//  6 RESP_TIMEOUT_EN, TIMEOUT_CYC=50, no rx_rdy -> timeout=1 after 50 RESP cycles, IDLE;
//    next snd_cmd clears timeout.

Source files
------------

// File: rtl/cmd_issuer.sv
// Host-side command issuer: sends a 16-bit command as two UART bytes (high first), then waits for one response byte.
// Optional response timeout is enabled with `define RESP_TIMEOUT_EN (TIMEOUT_CYC sets the limit).
module cmd_issuer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, RESP} state_t;

  state_t     state;
  // Only the low byte needs holding: the high byte goes out on the accept cycle.
  logic [7:0] cmd_reg;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cmd_issuer: TIMEOUT_CYC must be at least 2");
  end

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  assign cnt_done = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Every received byte is consumed at once; only in RESP is it kept as the response.
  assign clr_rx_rdy = rx_rdy;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_reg  <= 8'h00;
      tx_data  <= 8'h00;
      trmt     <= 1'b0;
      cmd_snt  <= 1'b0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timeout  <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            cmd_reg  <= cmd[7:0];
            cmd_snt  <= 1'b0;
            resp_rdy <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            trmt     <= 1'b1;
            tx_data  <= cmd[15:8];
            state    <= HIGH;
          end
        end
        // The !trmt guard keeps trmt from ever being high on back-to-back cycles.
        HIGH: begin
          if (tx_done && !trmt) begin
            trmt    <= 1'b1;
            tx_data <= cmd_reg;
            state   <= LOW;
          end
        end
        LOW: begin
          if (tx_done && !trmt) begin
            cmd_snt <= 1'b1;
`ifdef RESP_TIMEOUT_EN
            cnt     <= '0;
`endif
            state   <= RESP;
          end
        end
        RESP: begin
          if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            state    <= IDLE;
          end
`ifdef RESP_TIMEOUT_EN
          else if (cnt_done) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: directed scenarios plus randomized transactions against a transaction-level model.
module tb_cmd_issuer;

  localparam int unsigned TO_CYC = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        busy;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: bytes still owed on the link and the host-visible flags.
  logic [7:0] byte_q[$];
  logic [7:0] m_resp;
  logic       m_resp_rdy, m_cmd_snt, m_timeout;
  logic [7:0] m_last_tx;

  cmd_issuer #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".cmd_snt"},  16'(cmd_snt),  16'(m_cmd_snt));
    chk({tag, ".resp"},     16'(resp),     16'(m_resp));
    chk({tag, ".resp_rdy"}, 16'(resp_rdy), 16'(m_resp_rdy));
    chk({tag, ".timeout"},  16'(timeout),  16'(m_timeout));
  endtask

  // Expect a trmt pulse carrying the next owed byte.
  task automatic expect_byte(input string tag);
    logic [7:0] b;
    b = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hxx;
    m_last_tx = b;
    chk({tag, ".trmt"},    16'(trmt),    16'd1);
    chk({tag, ".tx_data"}, 16'(tx_data), 16'(b));
  endtask

  task automatic idle_gap(input int n, input logic exp_busy, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".gap_trmt"}, 16'(trmt), 16'd0);
      chk({tag, ".gap_busy"}, 16'(busy), 16'(exp_busy));
    end
    chk({tag, ".hold_tx_data"}, 16'(tx_data), 16'(m_last_tx));
  endtask

  task automatic accept(input logic [15:0] c, input bit coinc);
    cmd = c;
    snd_cmd = 1'b1;
    if (coinc) begin
      rx_rdy = 1'b1;
      rx_data = 8'h5A;
      #1 chk("idle_stray.clr", 16'(clr_rx_rdy), 16'd1);
    end
    tick();
    snd_cmd = 1'b0;
    rx_rdy = 1'b0;
    cmd = 16'($urandom);
    byte_q.push_back(c[15:8]);
    byte_q.push_back(c[7:0]);
    m_cmd_snt = 1'b0;
    m_resp_rdy = 1'b0;
    m_timeout = 1'b0;
    expect_byte("hi_byte");
    chk("accept.busy", 16'(busy), 16'd1);
    chk_flags("accept");
  endtask

  task automatic intrude(input string tag);
    cmd = 16'h4002;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    chk({tag, ".trmt"}, 16'(trmt), 16'd0);
    chk_flags(tag);
  endtask

  task automatic high_phase(input int g, input bit stray, input bit intr);
    if (intr) intrude("busy_snd_high");
    if (stray) begin
      rx_data = 8'h33;
      rx_rdy = 1'b1;
      #1 chk("stray_high.clr", 16'(clr_rx_rdy), 16'd1);
      tick();
      rx_rdy = 1'b0;
      chk_flags("stray_high");
    end
    idle_gap(g, 1'b1, "high");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    expect_byte("lo_byte");
  endtask

  task automatic low_phase(input int g, input bit intr);
    if (intr) intrude("busy_snd_low");
    idle_gap(g, 1'b1, "low");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    m_cmd_snt = 1'b1;
    chk("sent.trmt", 16'(trmt), 16'd0);
    chk("sent.busy", 16'(busy), 16'd1);
    chk_flags("sent");
  endtask

  task automatic resp_phase(input int g, input logic [7:0] r);
    idle_gap(g, 1'b1, "resp_wait");
    chk_flags("resp_wait");
    rx_data = r;
    rx_rdy = 1'b1;
    #1 chk("resp.clr", 16'(clr_rx_rdy), 16'd1);
    tick();
    rx_rdy = 1'b0;
    m_resp = r;
    m_resp_rdy = 1'b1;
    chk("resp.busy", 16'(busy), 16'd0);
    chk_flags("resp");
    // A tx_done in IDLE must not start anything.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_txdone.trmt", 16'(trmt), 16'd0);
    chk("idle_txdone.busy", 16'(busy), 16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".tx_data"},  16'(tx_data),  16'd0);
    chk({tag, ".trmt"},     16'(trmt),     16'd0);
    chk({tag, ".clr"},      16'(clr_rx_rdy), 16'd0);
    chk({tag, ".busy"},     16'(busy),     16'd0);
    chk_flags(tag);
  endtask

  initial begin
    rst = 1'b1;
    cmd = 16'h0000;
    snd_cmd = 1'b0;
    tx_done = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    m_resp = 8'h00;
    m_resp_rdy = 1'b0;
    m_cmd_snt = 1'b0;
    m_timeout = 1'b0;
    m_last_tx = 8'h00;
    #2 chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    idle_gap(3, 1'b0, "post_reset");

    // Nominal command 0x2BFF with ack 0xA5
    accept(16'h2BFF, 1'b0);
    high_phase(19, 1'b0, 1'b0);
    low_phase(19, 1'b0);
    resp_phase(5, 8'hA5);

    // Busy requests ignored, stray byte in HIGH, stray byte coincident with accept
    accept(16'h2BFF, 1'b1);
    high_phase(4, 1'b1, 1'b1);
    low_phase(4, 1'b1);
    resp_phase(2, 8'h3C);

    // Reset in LOW aborts silently
    accept(16'h1234, 1'b0);
    high_phase(3, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    byte_q.delete();
    m_resp = 8'h00;
    m_resp_rdy = 1'b0;
    m_cmd_snt = 1'b0;
    m_timeout = 1'b0;
    m_last_tx = 8'h00;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    idle_gap(30, 1'b0, "after_abort");

`ifdef RESP_TIMEOUT_EN
    // No response: timeout after TO_CYC cycles in RESP
    accept(16'hC0DE, 1'b0);
    high_phase(2, 1'b0, 1'b0);
    low_phase(2, 1'b0);
    repeat (TO_CYC - 1) tick();
    chk("to_pre.busy", 16'(busy), 16'd1);
    chk_flags("to_pre");
    tick();
    m_timeout = 1'b1;
    chk("to.busy", 16'(busy), 16'd0);
    chk_flags("to");
    accept(16'hBEEF, 1'b0);
    high_phase(2, 1'b0, 1'b0);
    low_phase(2, 1'b0);
    resp_phase(TO_CYC - 2, 8'h77);
`else
    // Without the timeout the response may arrive arbitrarily late
    accept(16'hC0DE, 1'b0);
    high_phase(2, 1'b0, 1'b0);
    low_phase(2, 1'b0);
    resp_phase(120, 8'h77);
`endif

    for (int n = 0; n < 10; n++) begin
      accept(16'($urandom), 1'($urandom_range(0, 1)));
      high_phase(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      low_phase(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
      resp_phase(int'($urandom_range(1, 20)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
